ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL: clk  input  1  pipeline clock, rising edge active.
REQ-002 SHALL: rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL: valid_in  input  1  ID/EX holds a real instruction (0 = bubble).
REQ-004 SHALL: RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, ALUSrc_in  input  1 each  control bits from ID/EX.
REQ-005 SHALL: ALUOp_in  input  2  00 add, 01 sub, 10 R-type, 11 I-type.
REQ-006 SHALL: rs1_data_in, rs2_data_in, imm_in  input  32 each  operands from ID/EX.
REQ-007 SHALL: funct3_in  input  3; funct7_in  input  7  instruction function fields.
REQ-008 SHALL: rs1_in, rs2_in, rd_in  input  5 each  register addresses from ID/EX.
REQ-009 SHALL: memwb_RegWrite  input  1; memwb_rd  input  5; memwb_data  input  32  write-back forwarding source.
REQ-010 SHALL: flush_in  input  1  discard the instruction in EX (branch redirect).
REQ-011 SHALL: stall_out  output  1  EX busy; ID/EX and earlier stages hold.
REQ-012 SHALL: RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out  output  1 each  registered EX/MEM control.
REQ-013 SHALL: alu_result_out, store_data_out  output  32 each  registered result and forwarded rs2 value.
REQ-014 SHALL: rd_out  output  5; zero_out  output  1  registered destination and result==0 flag.

Function
REQ-015 SHALL: operand A = forwarded rs1; operand B = imm_in if ALUSrc_in, else forwarded rs2.
REQ-016 SHALL: forwarding priority: own EX/MEM (RegWrite_out && !MemtoReg_out && rd_out==rsX && rd_out!=0), then MEM/WB (memwb_RegWrite && memwb_rd==rsX && memwb_rd!=0), else ID/EX data.
REQ-017 SHALL: ALUOp 10 decode: funct3 000 ADD (SUB if funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7[5]), 110 OR, 111 AND.
REQ-018 SHALL: ALUOp 11 decode identical to REQ-017, except funct3 000 is always ADD.
REQ-019 SHALL: shift amount = B[4:0]; all arithmetic 32-bit modulo 2^32; SLT signed, SLTU unsigned.
REQ-020 SHALL: single-cycle ops register result, controls, rd and store data into EX/MEM on the next rising edge (latency 1).
REQ-021 SHALL: valid_in=0 or flush_in=1 loads a bubble: RegWrite/MemRead/MemWrite outputs 0, data outputs don't-care.
REQ-022 SHALL: stall_out is combinational, high when FSM in MUL_BUSY, or in IDLE with a valid, unflushed MUL presented.
REQ-023 SHALL: a bubble is written into EX/MEM on every edge while stall_out=1.

Reset
REQ-024 SHALL: rst low clears all registered outputs to 0, FSM to IDLE, counter to 0, immediately and independent of clk.
REQ-025 SHALL: reset during MUL_BUSY abandons the multiply with no result produced.

Configuration
REQ-026 SHALL: macro EX_STAGE_MUL_EN compiles in RV32M MUL (ALUOp 10, funct7 0000001, funct3 000; low 32 bits).
REQ-027 SHALL: with the macro, the FSM has states IDLE -> MUL_BUSY (on MUL accepted; latch forwarded A, B; count=0) -> MUL_BUSY for 32 shift-add cycles -> MUL_DONE -> IDLE.
REQ-028 SHALL: MUL_DONE drives stall_out=0 and registers the product with the latched controls; first issue to result = 34 edges.
REQ-029 SHALL: flush_in in MUL_BUSY returns the FSM to IDLE next edge with a bubble output; flush_in in MUL_DONE suppresses the result.
REQ-030 SHALL: without the macro, no FSM exists, stall_out is tied 0, and funct7 0000001 decodes per REQ-017 (funct7[5]=0).

Verification
REQ-031 SHALL: ADD x3=5+7 (ALUOp 10, funct3 000, funct7 0) -> next edge alu_result_out=12, rd_out=3, RegWrite_out=1.
REQ-032 SHALL: back-to-back x1 producer (result 9) then consumer rs1=x1 with stale rs1_data_in=0, memwb rd=1 data=4 -> EX/MEM forwarding wins, consumer sees A=9.
REQ-033 SHALL: SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1<0xFFFFFFFF -> 1; SUB 5-5 -> zero_out=1.
REQ-034 SHALL: MUL_EN: MUL 0x10000 x 0x10001 -> stall_out high 33 cycles, then alu_result_out=0x00010000 with RegWrite_out=1.
REQ-035 SHALL: MUL_EN: flush_in at 10th busy cycle -> IDLE next edge, RegWrite_out=0, stall_out=0; rst low mid-MUL -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ===== ex_stage : RV32I execute stage with EX/MEM pipeline register and operand forwarding. rev 1.0
// ===== Define EX_STAGE_MUL_EN to add a 32-cycle shift-add MUL that stalls the front end.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        ALUSrc_in,
   input  logic [1:0]  ALUOp_in,
   input  logic [31:0] rs1_data_in,
   input  logic [31:0] rs2_data_in,
   input  logic [31:0] imm_in,
   input  logic [2:0]  funct3_in,
   input  logic [6:0]  funct7_in,
   input  logic [4:0]  rs1_in,
   input  logic [4:0]  rs2_in,
   input  logic [4:0]  rd_in,
   input  logic        memwb_RegWrite,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_data,
   input  logic        flush_in,
   output logic        stall_out,
   output logic        RegWrite_out,
   output logic        MemtoReg_out,
   output logic        MemRead_out,
   output logic        MemWrite_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] store_data_out,
   output logic [4:0]  rd_out,
   output logic        zero_out
);

   logic        regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
   logic        memread_q, memread_d, memwrite_q, memwrite_d;
   logic        zero_q, zero_d, bubble_w;
   logic [31:0] result_q, result_d, store_q, store_d;
   logic [4:0]  rd_q, rd_d, shamt_w;
   logic        issue_w, exmem_ok_w, memwb_ok_w;
   logic [31:0] opa_w, fwd_b_w, opb_w, alu_w;
   logic signed [31:0] sra_w;

   assign issue_w    = valid_in && !flush_in;
   // Only ALU results are forwardable from EX/MEM; load data is not available yet.
   assign exmem_ok_w = regwrite_q && !memtoreg_q && (rd_q != 5'd0);
   assign memwb_ok_w = memwb_RegWrite && (memwb_rd != 5'd0);

   assign opa_w   = (exmem_ok_w && rd_q == rs1_in)     ? result_q   :
                    (memwb_ok_w && memwb_rd == rs1_in) ? memwb_data : rs1_data_in;
   assign fwd_b_w = (exmem_ok_w && rd_q == rs2_in)     ? result_q   :
                    (memwb_ok_w && memwb_rd == rs2_in) ? memwb_data : rs2_data_in;
   assign opb_w   = ALUSrc_in ? imm_in : fwd_b_w;
   assign shamt_w = opb_w[4:0];
   assign sra_w   = $signed(opa_w) >>> shamt_w;

   always_comb begin
      alu_w = opa_w + opb_w;
      case (ALUOp_in)
         2'b00: alu_w = opa_w + opb_w;
         2'b01: alu_w = opa_w - opb_w;
         default: begin
            case (funct3_in)
               3'b000: alu_w = (ALUOp_in == 2'b10 && funct7_in[5]) ? opa_w - opb_w : opa_w + opb_w;
               3'b001: alu_w = opa_w << shamt_w;
               3'b010: alu_w = {31'd0, ($signed(opa_w) < $signed(opb_w))};
               3'b011: alu_w = {31'd0, (opa_w < opb_w)};
               3'b100: alu_w = opa_w ^ opb_w;
               3'b101: alu_w = funct7_in[5] ? sra_w : (opa_w >> shamt_w);
               3'b110: alu_w = opa_w | opb_w;
               default: alu_w = opa_w & opb_w;
            endcase
         end
      endcase
   end

`ifdef EX_STAGE_MUL_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL_BUSY = 2'd1, S_MUL_DONE = 2'd2} state_t;
   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d, m_rd_q, m_rd_d;
   logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, m_store_q, m_store_d;
   logic        m_rw_q, m_rw_d, m_mtr_q, m_mtr_d, m_mr_q, m_mr_d, m_mw_q, m_mw_d;
   logic        is_mul_w;

   assign is_mul_w  = (ALUOp_in == 2'b10) && (funct7_in == 7'b0000001) && (funct3_in == 3'b000);
   assign stall_out = (state_q == S_MUL_BUSY) || (state_q == S_IDLE && issue_w && is_mul_w);
`else
   logic unused_f7_w;
   assign unused_f7_w = ^{funct7_in[6], funct7_in[4:0]};
   assign stall_out   = 1'b0;
`endif

   always_comb begin
      bubble_w   = !issue_w;
      regwrite_d = RegWrite_in;
      memtoreg_d = MemtoReg_in;
      memread_d  = MemRead_in;
      memwrite_d = MemWrite_in;
      result_d   = alu_w;
      store_d    = fwd_b_w;
      rd_d       = rd_in;
      zero_d     = (alu_w == 32'd0);
`ifdef EX_STAGE_MUL_EN
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      m_rw_d    = m_rw_q;
      m_mtr_d   = m_mtr_q;
      m_mr_d    = m_mr_q;
      m_mw_d    = m_mw_q;
      m_rd_d    = m_rd_q;
      m_store_d = m_store_q;
      case (state_q)
         S_IDLE: begin
            if (issue_w && is_mul_w) begin
               bubble_w  = 1'b1;
               state_d   = S_MUL_BUSY;
               cnt_d     = 5'd0;
               mcand_d   = opa_w;
               mplier_d  = opb_w;
               acc_d     = 32'd0;
               m_rw_d    = RegWrite_in;
               m_mtr_d   = MemtoReg_in;
               m_mr_d    = MemRead_in;
               m_mw_d    = MemWrite_in;
               m_rd_d    = rd_in;
               m_store_d = fwd_b_w;
            end
         end
         S_MUL_BUSY: begin
            bubble_w = 1'b1;
            if (flush_in) begin
               state_d = S_IDLE;
            end else begin
               acc_d    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_d = S_MUL_DONE;
            end
         end
         S_MUL_DONE: begin
            // The held ID/EX contents are ignored here; the product retires with the latched controls.
            state_d    = S_IDLE;
            bubble_w   = flush_in;
            regwrite_d = m_rw_q;
            memtoreg_d = m_mtr_q;
            memread_d  = m_mr_q;
            memwrite_d = m_mw_q;
            result_d   = acc_q;
            store_d    = m_store_q;
            rd_d       = m_rd_q;
            zero_d     = (acc_q == 32'd0);
         end
         default: state_d = S_IDLE;
      endcase
`endif
      if (bubble_w) begin
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         result_d   = 32'd0;
         store_d    = 32'd0;
         rd_d       = 5'd0;
         zero_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         result_q   <= 32'd0;
         store_q    <= 32'd0;
         rd_q       <= 5'd0;
         zero_q     <= 1'b0;
`ifdef EX_STAGE_MUL_EN
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         mcand_q   <= 32'd0;
         mplier_q  <= 32'd0;
         acc_q     <= 32'd0;
         m_rw_q    <= 1'b0;
         m_mtr_q   <= 1'b0;
         m_mr_q    <= 1'b0;
         m_mw_q    <= 1'b0;
         m_rd_q    <= 5'd0;
         m_store_q <= 32'd0;
`endif
      end else begin
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         result_q   <= result_d;
         store_q    <= store_d;
         rd_q       <= rd_d;
         zero_q     <= zero_d;
`ifdef EX_STAGE_MUL_EN
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         m_rw_q    <= m_rw_d;
         m_mtr_q   <= m_mtr_d;
         m_mr_q    <= m_mr_d;
         m_mw_q    <= m_mw_d;
         m_rd_q    <= m_rd_d;
         m_store_q <= m_store_d;
`endif
      end
   end

   assign RegWrite_out   = regwrite_q;
   assign MemtoReg_out   = memtoreg_q;
   assign MemRead_out    = memread_q;
   assign MemWrite_out   = memwrite_q;
   assign alu_result_out = result_q;
   assign store_data_out = store_q;
   assign rd_out         = rd_q;
   assign zero_out       = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// tb_ex_stage: randomized scoreboard bench for ex_stage against an instruction-level reference model.
module tb_ex_stage;

`ifdef EX_STAGE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b0;
   logic        valid_in = 0, RegWrite_in = 0, MemtoReg_in = 0, MemRead_in = 0, MemWrite_in = 0, ALUSrc_in = 0;
   logic [1:0]  ALUOp_in = 0;
   logic [31:0] rs1_data_in = 0, rs2_data_in = 0, imm_in = 0, memwb_data = 0;
   logic [2:0]  funct3_in = 0;
   logic [6:0]  funct7_in = 0;
   logic [4:0]  rs1_in = 0, rs2_in = 0, rd_in = 0, memwb_rd = 0;
   logic        memwb_RegWrite = 0, flush_in = 0;
   logic        stall_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, zero_out;
   logic [31:0] alu_result_out, store_data_out;
   logic [4:0]  rd_out;

   ex_stage dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
      .MemWrite_in(MemWrite_in), .ALUSrc_in(ALUSrc_in), .ALUOp_in(ALUOp_in),
      .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
      .funct3_in(funct3_in), .funct7_in(funct7_in),
      .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
      .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .flush_in(flush_in), .stall_out(stall_out),
      .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .MemRead_out(MemRead_out),
      .MemWrite_out(MemWrite_out), .alu_result_out(alu_result_out),
      .store_data_out(store_data_out), .rd_out(rd_out), .zero_out(zero_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic v, rw, mtr, mr, mw, src;
      logic [1:0]  op;
      logic [31:0] a, b, imm;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rs1, rs2, rd;
   } instr_t;

   typedef struct packed {
      logic bub, rw, mtr, mr, mw, zero;
      logic [4:0]  rd;
      logic [31:0] res, st;
   } exp_t;

   exp_t scq[$];
   int   nchk = 0, nerr = 0;
   bit   mon_en = 1'b0;
   bit   exp_stall = 1'b0;
   exp_t prev = '0, latched = '0;
   int   busy_left = 0;
   bit   done_pend = 1'b0;

   function automatic logic [31:0] ref_alu(input instr_t in, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] pow2;
      logic [63:0] wide;
      pow2 = 32'd1 << b[4:0];
      if (in.op == 2'd0) return a + b;
      if (in.op == 2'd1) return a - b;
      case (in.f3)
         3'd0: return (in.op == 2'd2 && in.f7[5]) ? a - b : a + b;
         3'd1: begin wide = {32'd0, a} * {32'd0, pow2}; return wide[31:0]; end
         3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: begin
            if (!in.f7[5]) return a / pow2;
            wide = {{32{a[31]}}, a} >> b[4:0];
            return wide[31:0];
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] d,
                                       input bit wrw, input logic [4:0] wrd, input logic [31:0] wd);
      if (prev.rw && !prev.mtr && prev.rd == rs && rs != 5'd0) return prev.res;
      if (wrw && wrd == rs && rs != 5'd0) return wd;
      return d;
   endfunction

   // One EX cycle of the reference: what EX/MEM holds after the next edge, and whether EX stalls now.
   task automatic model(input instr_t in, input bit fl, input bit wrw, input logic [4:0] wrd,
                        input logic [31:0] wd, output exp_t e, output bit st);
      logic [31:0] a, b2, bop, r;
      logic [63:0] p;
      st = 1'b0;
      e = '0;
      e.bub = 1'b1;
      if (busy_left > 0) begin
         st = 1'b1;
         if (fl) busy_left = 0;
         else begin
            busy_left--;
            if (busy_left == 0) done_pend = 1'b1;
         end
      end else if (done_pend) begin
         done_pend = 1'b0;
         if (!fl) e = latched;
      end else begin
         a   = fwd(in.rs1, in.a, wrw, wrd, wd);
         b2  = fwd(in.rs2, in.b, wrw, wrd, wd);
         bop = in.src ? in.imm : b2;
         if (MUL_EN && in.v && !fl && in.op == 2'd2 && in.f7 == 7'd1 && in.f3 == 3'd0) begin
            st = 1'b1;
            busy_left = 32;
            p = {32'd0, a} * {32'd0, bop};
            latched = '{bub: 1'b0, rw: in.rw, mtr: in.mtr, mr: in.mr, mw: in.mw,
                        zero: (p[31:0] == 32'd0), rd: in.rd, res: p[31:0], st: b2};
         end else if (in.v && !fl) begin
            r = ref_alu(in, a, bop);
            e = '{bub: 1'b0, rw: in.rw, mtr: in.mtr, mr: in.mr, mw: in.mw,
                  zero: (r == 32'd0), rd: in.rd, res: r, st: b2};
         end
      end
      prev = e;
   endtask

   task automatic drive(input instr_t in, input bit fl, input bit wrw, input logic [4:0] wrd, input logic [31:0] wd);
      valid_in = in.v;  RegWrite_in = in.rw; MemtoReg_in = in.mtr; MemRead_in = in.mr;
      MemWrite_in = in.mw; ALUSrc_in = in.src; ALUOp_in = in.op;
      rs1_data_in = in.a; rs2_data_in = in.b; imm_in = in.imm;
      funct3_in = in.f3; funct7_in = in.f7; rs1_in = in.rs1; rs2_in = in.rs2; rd_in = in.rd;
      flush_in = fl; memwb_RegWrite = wrw; memwb_rd = wrd; memwb_data = wd;
   endtask

   task automatic step(input instr_t in, input bit fl, input bit wrw, input logic [4:0] wrd, input logic [31:0] wd);
      exp_t e;
      bit   st;
      @(negedge clk);
      drive(in, fl, wrw, wrd, wd);
      model(in, fl, wrw, wrd, wd, e, st);
      scq.push_back(e);
      exp_stall = st;
      mon_en = 1'b1;
      #1;
      nchk++;
      if (stall_out !== st) begin
         nerr++;
         $display("FAIL stall t=%0t got=%b exp=%b", $time, stall_out, st);
      end
   endtask

   task automatic step_r(input instr_t in, input bit fl);
      step(in, fl, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
   endtask

   // Presents an instruction and holds it for as long as EX reports busy.
   task automatic issue(input instr_t in, input int flush_pct, input int busy_flush_pm);
      int n = 0;
      step_r(in, ($urandom_range(0, 99) < flush_pct));
      while (exp_stall && n < 40) begin
         n++;
         step_r(in, ($urandom_range(0, 999) < busy_flush_pm));
      end
   endtask

   function automatic instr_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic src, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd);
      instr_t i;
      i = '0;
      i.v = 1'b1; i.rw = 1'b1; i.op = op; i.f3 = f3; i.f7 = f7; i.src = src;
      i.a = a; i.b = b; i.imm = imm; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
      return i;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   function automatic instr_t rnd_instr();
      instr_t i;
      logic [6:0] f7s [4];
      f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'($urandom);
      i.v = ($urandom_range(0, 7) != 0);
      i.rw = 1'($urandom); i.mtr = 1'($urandom); i.mr = 1'($urandom); i.mw = 1'($urandom);
      i.src = 1'($urandom); i.op = 2'($urandom);
      i.a = pick(); i.b = pick(); i.imm = pick();
      i.f3 = 3'($urandom); i.f7 = f7s[$urandom_range(0, 3)];
      i.rs1 = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3)); i.rd = 5'($urandom_range(0, 3));
      return i;
   endfunction

   task automatic async_reset_check();
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      drive('0, 1'b0, 1'b0, 5'd0, 32'd0);
      rst = 1'b0;
      #1;
      nchk++;
      if ({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, zero_out, stall_out} !== 6'd0 ||
          alu_result_out !== 32'd0 || store_data_out !== 32'd0 || rd_out !== 5'd0) begin
         nerr++;
         $display("FAIL async_reset got rw=%b res=%h st=%h rd=%0d zero=%b stall=%b exp all 0",
                  RegWrite_out, alu_result_out, store_data_out, rd_out, zero_out, stall_out);
      end
      scq.delete();
      prev = '0; busy_left = 0; done_pend = 1'b0; exp_stall = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      bit   ok;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            nchk++;
            if (scq.size() == 0) begin
               nerr++;
               $display("FAIL exmem_queue t=%0t got empty scoreboard exp an entry", $time);
            end else begin
               e  = scq.pop_front();
               ok = (RegWrite_out === e.rw) && (MemRead_out === e.mr) && (MemWrite_out === e.mw);
               if (!e.bub)
                  ok = ok && (MemtoReg_out === e.mtr) && (rd_out === e.rd) && (alu_result_out === e.res) &&
                       (store_data_out === e.st) && (zero_out === e.zero);
               if (!ok) begin
                  nerr++;
                  $display("FAIL exmem t=%0t got rw=%b mtr=%b mr=%b mw=%b rd=%0d res=%h st=%h z=%b exp bub=%b rw=%b mtr=%b mr=%b mw=%b rd=%0d res=%h st=%h z=%b",
                           $time, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, rd_out,
                           alu_result_out, store_data_out, zero_out, e.bub, e.rw, e.mtr, e.mr, e.mw,
                           e.rd, e.res, e.st, e.zero);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      nerr++;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      instr_t i;
      #1;
      nchk++;
      if ({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, zero_out, stall_out} !== 6'd0 ||
          alu_result_out !== 32'd0 || store_data_out !== 32'd0 || rd_out !== 5'd0) begin
         nerr++;
         $display("FAIL reset_state got rw=%b res=%h rd=%0d exp all 0", RegWrite_out, alu_result_out, rd_out);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;

      step(mk(2'd2, 3'd0, 7'h00, 1'b0, 32'd5, 32'd7, 32'd0, 5'd5, 5'd6, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk(2'd0, 3'd0, 7'h00, 1'b1, 32'd4, 32'd0, 32'd5, 5'd7, 5'd8, 5'd1), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk(2'd0, 3'd0, 7'h00, 1'b1, 32'd0, 32'd0, 32'd0, 5'd1, 5'd9, 5'd2), 1'b0, 1'b1, 5'd1, 32'd4);
      step(mk(2'd2, 3'd5, 7'h20, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd8, 5'd9, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk(2'd2, 3'd3, 7'h00, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd8, 5'd9, 5'd5), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk(2'd2, 3'd0, 7'h20, 1'b0, 32'd5, 32'd5, 32'd0, 5'd8, 5'd9, 5'd6), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk(2'd3, 3'd0, 7'h20, 1'b1, 32'd5, 32'd0, 32'd3, 5'd8, 5'd9, 5'd7), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk(2'd3, 3'd5, 7'h20, 1'b1, 32'hF000_0000, 32'd0, 32'd31, 5'd8, 5'd9, 5'd7), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk(2'd2, 3'd2, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd8, 5'd9, 5'd7), 1'b0, 1'b0, 5'd0, 32'd0);
      step(mk(2'd2, 3'd0, 7'h01, 1'b0, 32'd3, 32'd4, 32'd0, 5'd8, 5'd9, 5'd7), 1'b1, 1'b0, 5'd0, 32'd0);
      i = mk(2'd2, 3'd0, 7'h00, 1'b0, 32'd1, 32'd2, 32'd0, 5'd8, 5'd9, 5'd7);
      i.v = 1'b0;
      step(i, 1'b0, 1'b0, 5'd0, 32'd0);

      step(mk(2'd2, 3'd6, 7'h00, 1'b0, 32'h00F0_0F00, 32'h0F00_00F0, 32'd0, 5'd8, 5'd9, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0);
      async_reset_check();

      if (MUL_EN) begin
         issue(mk(2'd2, 3'd0, 7'h01, 1'b0, 32'h0001_0000, 32'h0001_0001, 32'd0, 5'd8, 5'd9, 5'd5), 0, 0);
         i = mk(2'd2, 3'd0, 7'h01, 1'b0, 32'd1234, 32'd5678, 32'd0, 5'd8, 5'd9, 5'd6);
         for (int k = 0; k < 10; k++) step(i, 1'b0, 1'b0, 5'd0, 32'd0);
         step(i, 1'b1, 1'b0, 5'd0, 32'd0);
         i.v = 1'b0;
         step(i, 1'b0, 1'b0, 5'd0, 32'd0);
         issue(mk(2'd2, 3'd0, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd8, 5'd9, 5'd2), 0, 0);
         i = mk(2'd2, 3'd0, 7'h01, 1'b0, 32'd77, 32'd99, 32'd0, 5'd8, 5'd9, 5'd6);
         for (int k = 0; k < 6; k++) step(i, 1'b0, 1'b0, 5'd0, 32'd0);
         async_reset_check();
         i.v = 1'b0;
         for (int k = 0; k < 40; k++) step(i, 1'b0, 1'b0, 5'd0, 32'd0);
      end

      for (int k = 0; k < 400; k++) issue(rnd_instr(), 12, 15);

      @(posedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire
